// File: rtl/mem_access_unit_if.sv
// Shared-bus and RAM-side signals of the memory access unit.
// slave = the access unit itself, master = the datapath/RAM side driving it.
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic [DATA_W-1:0] bus_in;
   logic              MARin;
   logic              MDRin;
   logic              rd_req;
   logic              wr_req;
   logic              err_clr;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] mdr_data_out;
   logic [ADDR_W-1:0] mar_data_out;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_re;
   logic              ram_we;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  bus_in, MARin, MDRin, rd_req, wr_req, err_clr, ram_rdata,
      output mdr_data_out, mar_data_out, ram_addr, ram_wdata,
             ram_re, ram_we, busy, done, err
   );

   modport master (
      output bus_in, MARin, MDRin, rd_req, wr_req, err_clr, ram_rdata,
      input  mdr_data_out, mar_data_out, ram_addr, ram_wdata,
             ram_re, ram_we, busy, done, err
   );
endinterface

// File: rtl/mem_access_unit.sv
// MAR/MDR pair plus read/write sequencer for a synchronous single-port RAM,
// with busy/done handshake, configurable wait states and a sticky misuse flag.
module mem_access_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 9,
   parameter int WAIT_STATES = 0
) (
   input  logic             clk,
   input  logic             clr,
   mem_access_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   // Read needs one extra cycle because the RAM returns data a cycle after it samples the address.
   localparam logic [4:0] RD_CNT = 5'(WAIT_STATES + 1);
   localparam logic [4:0] WR_CNT = 5'(WAIT_STATES);

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;
   logic              new_err;
   logic              busy_q, done_q, re_q, we_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      new_err = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.MARin) mar_d = bus.bus_in[ADDR_W-1:0];
            if (bus.MDRin) mdr_d = bus.bus_in;
            if (bus.rd_req && bus.wr_req) begin
               new_err = 1'b1;
            end else if (bus.rd_req) begin
               state_d = RD_WAIT;
               cnt_d   = RD_CNT;
            end else if (bus.wr_req) begin
               state_d = WR_WAIT;
               cnt_d   = WR_CNT;
            end
         end
         RD_WAIT: begin
            new_err = bus.MARin | bus.MDRin | bus.rd_req | bus.wr_req;
            if (cnt_q == 5'd0) begin
               mdr_d   = bus.ram_rdata;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         WR_WAIT: begin
            new_err = bus.MARin | bus.MDRin | bus.rd_req | bus.wr_req;
            if (cnt_q == 5'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh error at the same edge as err_clr keeps the flag set.
      err_d = new_err | (err_q & ~bus.err_clr);
   end

   // Handshake outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
         busy_q  <= (state_d == RD_WAIT) || (state_d == WR_WAIT);
         done_q  <= (state_d == DONE);
         re_q    <= (state_d == RD_WAIT);
         we_q    <= (state_d == WR_WAIT) && (cnt_d == 5'd0);
      end
   end

   assign bus.mdr_data_out = mdr_q;
   assign bus.mar_data_out = mar_q;
   assign bus.ram_addr     = mar_q;
   assign bus.ram_wdata    = mdr_q;
   assign bus.ram_re       = re_q;
   assign bus.ram_we       = we_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three instances (0, 2 and 3 wait states), each
// with its own RAM, checked against a cycle-offset timing model and memory image.
module tb_mem_access_unit;
   localparam int N = 3;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   logic [N-1:0][31:0] s_bus;
   logic [N-1:0]       s_marin, s_mdrin, s_rd, s_wr, s_eclr;
   logic [N-1:0][31:0] o_mdr, o_wdata, r_rdata;
   logic [N-1:0][8:0]  o_mar, o_addr;
   logic [N-1:0]       o_re, o_we, o_busy, o_done, o_err;

   logic [31:0] ram [N][512];
   logic [31:0] mdl [N][512];
   logic        poke_en;
   int          poke_k;
   logic [8:0]  poke_a;
   logic [31:0] poke_d;

   int   checks = 0;
   int   failures = 0;
   int   cur_k = 0;
   int   dcount = 0;
   logic cnt_en = 1'b0;

   for (genvar g = 0; g < N; g++) begin : gi
      localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      mem_access_unit_if #(.DATA_W(32), .ADDR_W(9)) ifc ();
      mem_access_unit #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(WS)) dut (
         .clk (clk),
         .clr (clr),
         .bus (ifc)
      );
      assign ifc.bus_in    = s_bus[g];
      assign ifc.MARin     = s_marin[g];
      assign ifc.MDRin     = s_mdrin[g];
      assign ifc.rd_req    = s_rd[g];
      assign ifc.wr_req    = s_wr[g];
      assign ifc.err_clr   = s_eclr[g];
      assign ifc.ram_rdata = r_rdata[g];
      assign o_mdr[g]      = ifc.mdr_data_out;
      assign o_mar[g]      = ifc.mar_data_out;
      assign o_addr[g]     = ifc.ram_addr;
      assign o_wdata[g]    = ifc.ram_wdata;
      assign o_re[g]       = ifc.ram_re;
      assign o_we[g]       = ifc.ram_we;
      assign o_busy[g]     = ifc.busy;
      assign o_done[g]     = ifc.done;
      assign o_err[g]      = ifc.err;
   end

   // Synchronous single-port RAMs plus a backdoor preload port.
   always @(posedge clk) begin
      if (poke_en) ram[poke_k][poke_a] <= poke_d;
      for (int k = 0; k < N; k++) begin
         if (o_we[k]) ram[k][o_addr[k]] <= o_wdata[k];
         if (o_re[k]) r_rdata[k] <= ram[k][o_addr[k]];
      end
   end

   always @(negedge clk) if (cnt_en && o_done[0] === 1'b1) dcount++;

   function automatic int wof(input int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL k%0d %s observed=%h expected=%h", cur_k, tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      chk(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   task automatic idle(input int k);
      s_bus[k]   = $urandom;
      s_marin[k] = 1'b0;
      s_mdrin[k] = 1'b0;
      s_rd[k]    = 1'b0;
      s_wr[k]    = 1'b0;
      s_eclr[k]  = 1'b0;
   endtask

   task automatic poke(input int k, input logic [8:0] a, input logic [31:0] d);
      poke_k  = k;
      poke_a  = a;
      poke_d  = d;
      poke_en = 1'b1;
      step();
      poke_en = 1'b0;
      mdl[k][a] = d;
   endtask

   task automatic zero_all(input string tag);
      for (int k = 0; k < N; k++) begin
         cur_k = k;
         chk({tag, " mdr"}, o_mdr[k], 32'h0);
         chk({tag, " wdata"}, o_wdata[k], 32'h0);
         chk({tag, " mar"}, 32'(o_mar[k]), 32'h0);
         chk({tag, " addr"}, 32'(o_addr[k]), 32'h0);
         chkb({tag, " re"}, o_re[k], 1'b0);
         chkb({tag, " we"}, o_we[k], 1'b0);
         chkb({tag, " busy"}, o_busy[k], 1'b0);
         chkb({tag, " done"}, o_done[k], 1'b0);
         chkb({tag, " err"}, o_err[k], 1'b0);
      end
   endtask

   // One transaction; ends in the done cycle unless tail asks for one more idle cycle.
   task automatic xact(input int k, input bit is_wr, input logic [8:0] a,
                       input logic [31:0] d, input bit tail);
      int w;
      int last;
      w     = wof(k);
      last  = is_wr ? w + 1 : w + 2;
      cur_k = k;
      idle(k);
      s_bus[k]   = {23'($urandom), a};
      s_marin[k] = 1'b1;
      if (is_wr) begin
         step();
         idle(k);
         s_bus[k]   = d;
         s_mdrin[k] = 1'b1;
         s_wr[k]    = 1'b1;
      end else begin
         s_rd[k] = 1'b1;
      end
      step();
      idle(k);
      for (int i = 0; i <= last; i++) begin
         chkb("busy", o_busy[k], i < last);
         chkb("done", o_done[k], i == last);
         chkb("ram_re", o_re[k], !is_wr && i < last);
         chkb("ram_we", o_we[k], is_wr && i == w);
         if (i == 0) chk("mar", 32'(o_mar[k]), 32'(a));
         if (i < last) step();
      end
      if (is_wr) begin
         mdl[k][a] = d;
         chk("ram word", ram[k][a], d);
      end else begin
         chk("mdr", o_mdr[k], mdl[k][a]);
      end
      if (tail) begin
         step();
         chkb("done tail", o_done[k], 1'b0);
         chkb("busy tail", o_busy[k], 1'b0);
      end
   endtask

   initial begin
      logic [8:0] wq[$];
      logic [8:0] a;
      logic [31:0] d;
      clr     = 1'b0;
      poke_en = 1'b0;
      for (int k = 0; k < N; k++) idle(k);
      repeat (2) @(posedge clk);
      #2 clr = 1'b1;
      step();

      // Reset mid-transaction with live inputs and a pending error.
      for (int k = 0; k < N; k++) begin
         s_bus[k] = $urandom; s_marin[k] = 1'b1; s_mdrin[k] = 1'b1;
         s_rd[k] = 1'b1; s_wr[k] = 1'b1;
      end
      step();
      for (int k = 0; k < N; k++) s_wr[k] = 1'b0;
      step();
      for (int k = 0; k < N; k++) begin
         s_bus[k] = $urandom; s_marin[k] = 1'($urandom); s_mdrin[k] = 1'($urandom);
         s_rd[k] = 1'($urandom); s_wr[k] = 1'($urandom); s_eclr[k] = 1'($urandom);
      end
      #2 clr = 1'b0;
      #1 zero_all("reset");
      step();
      zero_all("reset held");
      for (int k = 0; k < N; k++) idle(k);
      #3 clr = 1'b1;
      step();

      // Directed read (W=0) and write (W=3).
      poke(0, 9'd5, 32'hDEADBEEF);
      xact(0, 1'b0, 9'd5, 32'h0, 1'b1);
      xact(2, 1'b1, 9'h1FF, 32'h12345678, 1'b1);

      // Write then read accepted in the done cycle.
      cnt_en = 1'b1;
      xact(0, 1'b1, 9'h010, 32'hA5A5A5A5, 1'b0);
      xact(0, 1'b0, 9'h010, 32'h0, 1'b1);
      step();
      cnt_en = 1'b0;
      cur_k = 0;
      chk("done pulses", dcount, 32'd2);

      // Protocol misuse on the W=2 instance.
      poke(1, 9'h020, 32'hCAFEF00D);
      cur_k = 1;
      idle(1); s_rd[1] = 1'b1; s_wr[1] = 1'b1;
      step(); idle(1);
      chkb("both req busy", o_busy[1], 1'b0);
      chkb("both req err", o_err[1], 1'b1);
      chkb("both req done", o_done[1], 1'b0);
      step();
      chkb("err sticky", o_err[1], 1'b1);
      s_eclr[1] = 1'b1;
      step(); idle(1);
      chkb("err_clr", o_err[1], 1'b0);
      s_bus[1] = 32'h20; s_marin[1] = 1'b1; s_rd[1] = 1'b1;
      step(); idle(1);
      chkb("rd busy", o_busy[1], 1'b1);
      s_bus[1] = 32'h7; s_marin[1] = 1'b1;
      step(); idle(1);
      chk("mar held", 32'(o_mar[1]), 32'h20);
      chkb("busy load err", o_err[1], 1'b1);
      s_mdrin[1] = 1'b1; s_eclr[1] = 1'b1;
      step(); idle(1);
      chkb("new err wins", o_err[1], 1'b1);
      step();
      step();
      chkb("err rd done", o_done[1], 1'b1);
      chk("err rd mdr", o_mdr[1], 32'hCAFEF00D);
      s_eclr[1] = 1'b1;
      step(); idle(1);
      chkb("err cleared", o_err[1], 1'b0);

      // Abort a W=2 write just before its RAM write edge.
      poke(1, 9'h033, 32'h11111111);
      cur_k = 1;
      s_bus[1] = 32'h33; s_marin[1] = 1'b1;
      step(); idle(1);
      s_bus[1] = 32'h99999999; s_mdrin[1] = 1'b1; s_wr[1] = 1'b1;
      step(); idle(1);
      step();
      step();
      chkb("abort we before", o_we[1], 1'b1);
      #2 clr = 1'b0;
      #1 zero_all("abort");
      step();
      cur_k = 1;
      chkb("abort no done", o_done[1], 1'b0);
      #3 clr = 1'b1;
      step();
      cur_k = 1;
      chkb("abort done after", o_done[1], 1'b0);
      chkb("abort busy after", o_busy[1], 1'b0);
      chk("abort ram kept", ram[1][9'h033], 32'h11111111);

      // Random writes and read-backs on every instance.
      for (int k = 0; k < N; k++) begin
         wq.delete();
         for (int n = 0; n < 6; n++) begin
            a = 9'($urandom);
            d = $urandom;
            wq.push_back(a);
            xact(k, 1'b1, a, d, 1'($urandom));
            a = wq[$urandom_range(0, wq.size() - 1)];
            xact(k, 1'b0, a, 32'h0, 1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
